// File: rtl/shift_reg_seq_pkg.sv
// Shared definitions for the shift_reg_seq slice.
//  - mode_e  : shift mode codes (LOGICAL/ARITH/ROTATE/SERIAL)
//  - state_e : sequencer states (IDLE/SHIFT/DONE)
//  - fill_bit: selects the bit entering the register for one step
package shift_reg_seq_pkg;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'd0,
        MODE_ARITH   = 2'd1,
        MODE_ROTATE  = 2'd2,
        MODE_SERIAL  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // i_dir: 1 = right. i_msb is the current top bit, i_out the bit leaving.
    function automatic logic fill_bit(input mode_e i_mode, input logic i_dir,
                                      input logic i_msb, input logic i_out,
                                      input logic i_ser_in);
        logic w_fill;
        w_fill = 1'b0;
        case (i_mode)
            MODE_LOGICAL: w_fill = 1'b0;
            MODE_ARITH:   w_fill = i_dir ? i_msb : 1'b0;
            MODE_ROTATE:  w_fill = i_out;
            MODE_SERIAL:  w_fill = i_ser_in;
            default:      w_fill = 1'b0;
        endcase
        return w_fill;
    endfunction

endpackage

// File: rtl/shift_reg_seq_if.sv
// Control/data bundle for shift_reg_seq.
//  Driven by master: load, data, start, amount, mode, dir, ser_in
//  Driven by slave : q, ser_out, busy, done
interface shift_reg_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);

    logic             load;
    logic [WIDTH-1:0] data;
    logic             start;
    logic [CNT_W-1:0] amount;
    logic [1:0]       mode;
    logic             dir;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load, data, start, amount, mode, dir, ser_in,
        input  q, ser_out, busy, done
    );

    modport slave (
        input  load, data, start, amount, mode, dir, ser_in,
        output q, ser_out, busy, done
    );

endinterface

// File: rtl/shift_reg_seq_step.sv
// Combinational single-bit shift step.
//  i_q      current register value
//  i_mode   shift mode
//  i_dir    1 = right (toward bit 0), 0 = left
//  i_ser_in fill bit for SERIAL mode
//  o_q      register value after one step
//  o_out    bit that leaves the register on this step
module shift_reg_seq_step
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  mode_e            i_mode,
    input  logic             i_dir,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_q,
    output logic             o_out
);

    logic w_out;
    logic w_fill;

    always_comb begin
        w_out  = i_dir ? i_q[0] : i_q[WIDTH-1];
        w_fill = fill_bit(i_mode, i_dir, i_q[WIDTH-1], w_out, i_ser_in);
        if (i_dir) begin
            o_q = {w_fill, i_q[WIDTH-1:1]};
        end else begin
            o_q = {i_q[WIDTH-2:0], w_fill};
        end
        o_out = w_out;
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Universal shift register with a multi-step shift sequencer.
//  clk   rising-edge clock
//  rst_n asynchronous active-low reset
//  bus   slave side of shift_reg_seq_if:
//        load/data  parallel load (IDLE only, beats start)
//        start      begin 'amount' single-bit steps with captured mode/dir
//        ser_in     SERIAL fill bit, sampled every step
//        q          register contents
//        ser_out    bit shifted out on the last step (held outside SHIFT)
//        busy       high while in SHIFT
//        done       one-cycle pulse when a sequence completes
module shift_reg_seq
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            rst_n,
    shift_reg_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    mode_e            r_mode;
    logic             r_dir;
    logic [WIDTH-1:0] r_q;
    logic             r_ser_out;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_out;

    shift_reg_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q      (r_q),
        .i_mode   (r_mode),
        .i_dir    (r_dir),
        .i_ser_in (bus.ser_in),
        .o_q      (w_step_q),
        .o_out    (w_step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!bus.load && bus.start) begin
                    w_next_state = (bus.amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            // Counter holds steps still to do including this one.
            ST_SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_mode    <= MODE_LOGICAL;
            r_dir     <= 1'b0;
            r_q       <= '0;
            r_ser_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.load) begin
                        r_q <= bus.data;
                    end else if (bus.start) begin
                        r_cnt  <= bus.amount;
                        r_mode <= mode_e'(bus.mode);
                        r_dir  <= bus.dir;
                    end
                end
                ST_SHIFT: begin
                    r_q       <= w_step_q;
                    r_ser_out <= w_step_out;
                    r_cnt     <= r_cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.q       = r_q;
    assign bus.ser_out = r_ser_out;
    assign bus.busy    = (r_state == ST_SHIFT);
    assign bus.done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed self-checking bench for shift_reg_seq (WIDTH=8).
module tb_shift_reg_seq;
    import shift_reg_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    shift_reg_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_reg_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues start and waits (bounded) for done; lat = cycles from start edge to done.
    task automatic run(input logic [CNT_W-1:0] amt, input logic [1:0] md,
                       input logic d, output int lat);
        bus.start  = 1'b1;
        bus.amount = amt;
        bus.mode   = md;
        bus.dir    = d;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic load_word(input logic [WIDTH-1:0] v);
        bus.load = 1'b1;
        bus.data = v;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        int   lat;
        logic seen_done;
        logic [3:0] ser_bits;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.load  = 1'b0;
        bus.data  = '0;
        bus.start = 1'b0;
        bus.amount = '0;
        bus.mode  = 2'd0;
        bus.dir   = 1'b0;
        bus.ser_in = 1'b0;

        tick();
        chk("rst_q", bus.q, 32'h0);
        chk("rst_busy", bus.busy, 32'h0);
        chk("rst_done", bus.done, 32'h0);
        chk("rst_ser_out", bus.ser_out, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // LOGICAL right 3 from B4, stepped cycle by cycle
        load_word(8'hB4);
        chk("load_b4", bus.q, 32'hB4);
        bus.start = 1'b1; bus.amount = 4'd3; bus.mode = MODE_LOGICAL; bus.dir = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("lg_c1_busy", bus.busy, 32'h1);
        chk("lg_c1_q", bus.q, 32'hB4);
        tick();
        chk("lg_c2_q", bus.q, 32'h5A);
        chk("lg_c2_busy", bus.busy, 32'h1);
        tick();
        chk("lg_c3_q", bus.q, 32'h2D);
        chk("lg_c3_busy", bus.busy, 32'h1);
        tick();
        chk("lg_c4_done", bus.done, 32'h1);
        chk("lg_c4_busy", bus.busy, 32'h0);
        chk("lg_q", bus.q, 32'h16);
        chk("lg_ser_out", bus.ser_out, 32'h1);
        tick();
        chk("lg_done_pulse", bus.done, 32'h0);

        // ARITH right 2 from 81
        load_word(8'h81);
        run(4'd2, MODE_ARITH, 1'b1, lat);
        chk("ar_lat", lat, 32'd3);
        chk("ar_q", bus.q, 32'hE0);
        chk("ar_ser_out", bus.ser_out, 32'h0);
        tick();

        // ROTATE left 9 from 81 wraps to a 1-bit rotate
        load_word(8'h81);
        run(4'd9, MODE_ROTATE, 1'b0, lat);
        chk("ro_lat", lat, 32'd10);
        chk("ro_q", bus.q, 32'h03);
        chk("ro_ser_out", bus.ser_out, 32'h1);
        tick();

        // load does not clear ser_out
        load_word(8'h00);
        chk("ld_keeps_ser_out", bus.ser_out, 32'h1);

        // SERIAL left 4 with ser_in 1,0,1,1
        ser_bits = 4'b1101;
        bus.start = 1'b1; bus.amount = 4'd4; bus.mode = MODE_SERIAL; bus.dir = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ser_in = ser_bits[i];
            tick();
        end
        bus.ser_in = 1'b0;
        chk("se_done", bus.done, 32'h1);
        chk("se_q", bus.q, 32'h0B);
        chk("se_ser_out", bus.ser_out, 32'h0);
        tick();

        // load beats start in the same IDLE cycle
        bus.load = 1'b1; bus.data = 8'h5A;
        bus.start = 1'b1; bus.amount = 4'd3; bus.mode = MODE_LOGICAL; bus.dir = 1'b1;
        tick();
        bus.load = 1'b0; bus.start = 1'b0;
        chk("ls_q", bus.q, 32'h5A);
        chk("ls_busy", bus.busy, 32'h0);
        tick();
        chk("ls_busy2", bus.busy, 32'h0);
        chk("ls_done2", bus.done, 32'h0);

        // zero-length sequence
        run(4'd0, MODE_LOGICAL, 1'b1, lat);
        chk("z_lat", lat, 32'd1);
        chk("z_q", bus.q, 32'h5A);
        tick();
        chk("z_done_pulse", bus.done, 32'h0);

        // LOGICAL left 10 drains to zero
        load_word(8'hFF);
        run(4'd10, MODE_LOGICAL, 1'b0, lat);
        chk("dr_lat", lat, 32'd11);
        chk("dr_q", bus.q, 32'h00);
        tick();

        // ARITH right 12 saturates to sign
        load_word(8'h80);
        run(4'd12, MODE_ARITH, 1'b1, lat);
        chk("sat_q", bus.q, 32'hFF);
        tick();

        // ARITH left fills zero
        load_word(8'hC3);
        run(4'd1, MODE_ARITH, 1'b0, lat);
        chk("al_q", bus.q, 32'h86);
        tick();

        // inputs toggled during SHIFT are ignored
        load_word(8'hB4);
        bus.start = 1'b1; bus.amount = 4'd3; bus.mode = MODE_LOGICAL; bus.dir = 1'b1;
        tick();
        bus.load = 1'b1; bus.data = 8'hFF;
        bus.amount = 4'd7; bus.mode = MODE_ROTATE; bus.dir = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        bus.load = 1'b0; bus.start = 1'b0;
        chk("tg_lat", lat, 32'd4);
        chk("tg_q", bus.q, 32'h16);
        tick();
        chk("tg_q_idle", bus.q, 32'h16);
        chk("tg_busy_idle", bus.busy, 32'h0);

        // asynchronous reset mid-sequence
        load_word(8'hFF);
        run_partial: begin
            bus.start = 1'b1; bus.amount = 4'd5; bus.mode = MODE_LOGICAL; bus.dir = 1'b1;
            tick();
            bus.start = 1'b0;
            tick();
            tick();
        end
        chk("pre_rst_busy", bus.busy, 32'h1);
        chk("pre_rst_ser_out", bus.ser_out, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rst_q", bus.q, 32'h0);
        chk("ar_rst_busy", bus.busy, 32'h0);
        chk("ar_rst_done", bus.done, 32'h0);
        chk("ar_rst_ser_out", bus.ser_out, 32'h0);
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_done = seen_done | bus.done | bus.busy;
        end
        chk("no_done_after_rst", seen_done, 32'h0);
        chk("q_after_rst", bus.q, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
